// File: rtl/ray_dir_gen_pkg.sv
// Shared definitions for the ray direction generator.
// 27-bit float layout: [26] sign, [25:18] exponent (bias 127), [17:0] fraction
// with hidden leading one. Zero is the all-zero word.
package ray_dir_gen_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 18;
    localparam int FP_W    = 27;
    localparam int FP_BIAS = 127;

    localparam logic [FP_W-1:0] FP_ONE  = 27'h1FC0000;
    localparam logic [FP_W-1:0] FP_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/ray_dir_gen_int_to_fp.sv
// int_to_fp: combinational signed-magnitude to 27-bit float encoder.
// Value encoded is (sign ? -1 : 1) * mag * 2^-SCALE_SHIFT, exact (no rounding).
// Ports:
//   sign  in  1      sign of the value
//   mag   in  MAG_W  unsigned magnitude
//   fp    out 27     encoded float; zero magnitude gives all-zero bits
module int_to_fp
    import ray_dir_gen_pkg::*;
#(
    parameter int MAG_W       = 12,
    parameter int SCALE_SHIFT = 9
) (
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    output logic [FP_W-1:0]  fp
);

    int                msb;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;

    always_comb begin
        // Leading-one detect: last set bit seen while scanning upward wins.
        msb = 0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) msb = i;
        end
        expo = EXP_W'(FP_BIAS + msb - SCALE_SHIFT);
        // Shifting right by msb lands the leading one just above the fraction
        // field; truncation to FRAC_W then drops the hidden bit.
        frac = FRAC_W'({mag, {FRAC_W{1'b0}}} >> msb);
        fp   = (mag == '0) ? FP_ZERO : {sign, expo, frac};
    end

endmodule

// File: rtl/ray_dir_gen.sv
// ray_dir_gen: frame-scan ray source. Walks every pixel of an H_RES x V_RES
// frame in raster order and emits an unnormalised camera-space direction
// (x, y, 1.0) as 27-bit floats plus the pixel tag on a valid/ready stream.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start                 begin a frame when idle (ignored otherwise)
//   i_ready                 downstream accepts the current beat
//   o_valid                 beat valid
//   o_dir_x/o_dir_y/o_dir_z direction components (z fixed at 1.0)
//   o_pix_x/o_pix_y         pixel coordinates of the beat
//   o_sof/o_eof             first / last pixel of the frame
//   o_busy                  frame in progress, including drain
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int COORD_W     = 11,
    parameter int SCALE_SHIFT = 9
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [FP_W-1:0]    o_dir_x,
    output logic [FP_W-1:0]    o_dir_y,
    output logic [FP_W-1:0]    o_dir_z,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic               o_sof,
    output logic               o_eof,
    output logic               o_busy
);

    localparam int STAGES = 2;
    localparam int MAG_W  = COORD_W + 1;

    localparam logic signed [COORD_W:0] HALF_H = (COORD_W+1)'(H_RES / 2);
    localparam logic signed [COORD_W:0] HALF_V = (COORD_W+1)'(V_RES / 2);

    typedef struct packed {
        logic               sx;
        logic [MAG_W-1:0]   mx;
        logic               sy;
        logic [MAG_W-1:0]   my;
        logic [COORD_W-1:0] px;
        logic [COORD_W-1:0] py;
        logic               sof;
        logic               eof;
    } s1_t;

    state_e               state;
    logic [COORD_W-1:0]   cnt_x, cnt_y;
    logic [STAGES:1]      vld_q;
    logic [STAGES:0]      vld_pipe;
    logic                 advance, issue, last_pix;
    logic signed [COORD_W:0] dx, dy;
    s1_t                  s1_d, s1_q;
    logic [FP_W-1:0]      fp_x, fp_y;

    // The whole pipe moves together; only a held output beat stalls it.
    assign advance  = !(vld_q[STAGES] && !i_ready);
    assign issue    = (state == ST_RUN) && advance;
    assign vld_pipe = {vld_q, issue};
    assign last_pix = (cnt_x == COORD_W'(H_RES - 1)) && (cnt_y == COORD_W'(V_RES - 1));

    assign o_valid = vld_q[STAGES];
    assign o_dir_z = FP_ONE;
    assign o_busy  = (state != ST_IDLE);

    // S1 input: centred offsets, y flipped so up is positive.
    always_comb begin
        dx       = $signed({1'b0, cnt_x}) - HALF_H;
        dy       = HALF_V - $signed({1'b0, cnt_y});
        s1_d     = '0;
        s1_d.sx  = dx[COORD_W];
        s1_d.mx  = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        s1_d.sy  = dy[COORD_W];
        s1_d.my  = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        s1_d.px  = cnt_x;
        s1_d.py  = cnt_y;
        s1_d.sof = (cnt_x == '0) && (cnt_y == '0);
        s1_d.eof = last_pix;
    end

    // Frame FSM and raster counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt_x <= '0;
            cnt_y <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_RUN;
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_pix) state <= ST_DRAIN;
                        if (cnt_x == COORD_W'(H_RES - 1)) begin
                            cnt_x <= '0;
                            cnt_y <= (cnt_y == COORD_W'(V_RES - 1)) ? '0 : cnt_y + 1'b1;
                        end else begin
                            cnt_x <= cnt_x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (o_valid && i_ready && o_eof) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    int_to_fp #(.MAG_W(MAG_W), .SCALE_SHIFT(SCALE_SHIFT)) u_fp_x (
        .sign (s1_q.sx),
        .mag  (s1_q.mx),
        .fp   (fp_x)
    );

    int_to_fp #(.MAG_W(MAG_W), .SCALE_SHIFT(SCALE_SHIFT)) u_fp_y (
        .sign (s1_q.sy),
        .mag  (s1_q.my),
        .fp   (fp_y)
    );

    // S1 register and S2 output register. Payload loads freely when the pipe
    // advances; vld_q alone says whether a stage holds a real pixel.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q   <= '0;
            s1_q    <= '0;
            o_dir_x <= '0;
            o_dir_y <= '0;
            o_pix_x <= '0;
            o_pix_y <= '0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end else if (advance) begin
            vld_q   <= vld_pipe[STAGES-1:0];
            s1_q    <= s1_d;
            o_dir_x <= fp_x;
            o_dir_y <= fp_y;
            o_pix_x <= s1_q.px;
            o_pix_y <= s1_q.py;
            o_sof   <= s1_q.sof;
            o_eof   <= s1_q.eof;
        end
    end

endmodule

// File: tb/tb_ray_dir_gen.sv
// Bench for ray_dir_gen. A full-resolution instance checks the first beats
// against known encodings and latency; a reduced-frame instance is checked
// beat-by-beat against a real-arithmetic reference through a scoreboard.
module tb_ray_dir_gen;
    localparam int H  = 128;
    localparam int V  = 64;
    localparam int CW = 11;
    localparam int SS = 6;
    localparam int BW = 2*27 + 2*CW + 2;

    logic clk = 1'b0;
    logic rst, start, ready;
    logic valid, sof, eof, busy;
    logic [26:0] dir_x, dir_y, dir_z;
    logic [CW-1:0] pix_x, pix_y;

    logic start2, ready2;
    logic valid2, sof2, eof2, busy2;
    logic [26:0] dir_x2, dir_y2, dir_z2;
    logic [10:0] pix_x2, pix_y2;

    always #5 clk = ~clk;

    ray_dir_gen #(.H_RES(H), .V_RES(V), .COORD_W(CW), .SCALE_SHIFT(SS)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_ready(ready),
        .o_valid(valid), .o_dir_x(dir_x), .o_dir_y(dir_y), .o_dir_z(dir_z),
        .o_pix_x(pix_x), .o_pix_y(pix_y), .o_sof(sof), .o_eof(eof), .o_busy(busy)
    );

    ray_dir_gen dut_full (
        .i_clk(clk), .i_reset(rst), .i_start(start2), .i_ready(ready2),
        .o_valid(valid2), .o_dir_x(dir_x2), .o_dir_y(dir_y2), .o_dir_z(dir_z2),
        .o_pix_x(pix_x2), .o_pix_y(pix_y2), .o_sof(sof2), .o_eof(eof2), .o_busy(busy2)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference encoder using real arithmetic.
    function automatic logic [26:0] enc(input int off);
        real a;
        int  e;
        logic sgn;
        logic [17:0] f;
        if (off == 0) return 27'h0;
        sgn = (off < 0);
        a = real'(off < 0 ? -off : off) / (2.0 ** SS);
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f = 18'($rtoi((a - 1.0) * 262144.0));
        return {sgn, 8'(127 + e), f};
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int x, input int y);
        return {enc(x - H/2), enc(V/2 - y), CW'(x), CW'(y),
                (x == 0 && y == 0), (x == H-1 && y == V-1)};
    endfunction

    logic [BW-1:0] sbq[$];
    logic [BW-1:0] obs_b;
    logic [BW-1:0] prev;
    logic          stall_prev = 1'b0;
    logic          mon_en = 1'b0;
    logic          rand_ready = 1'b0;
    int            beats = 0;

    assign obs_b = {dir_x, dir_y, pix_x, pix_y, sof, eof};

    task automatic push_frame();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                sbq.push_back(exp_beat(x, y));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Output monitor: scoreboard pop on transfer, stability during stalls.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (stall_prev) begin
                chk("stall_valid", valid, 1);
                chk("stall_hold", obs_b, prev);
            end
            if (valid && ready) begin
                if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
                else chk("beat", obs_b, sbq.pop_front());
                if (pix_x == CW'(H/2) && pix_y == CW'(V/2))
                    chk("centre_zero", {dir_x, dir_y}, 0);
                beats++;
            end
            stall_prev = valid && !ready;
            prev = obs_b;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int  n;
        logic done;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dirz", dir_z, 27'h1FC0000);
        chk("rst_beat", obs_b, 0);
        chk("rst_valid2", valid2, 0);
        chk("rst_dirz2", dir_z2, 27'h1FC0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-resolution instance: latency and known encodings.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("lat_c1_valid", valid2, 0);
        chk("lat_c1_busy", busy2, 1);
        @(posedge clk); #1;
        chk("lat_c2_valid", valid2, 0);
        @(posedge clk); #1;
        chk("first_valid", valid2, 1);
        chk("first_pix", {pix_x2, pix_y2}, 0);
        chk("first_sof", sof2, 1);
        chk("first_dirx", dir_x2, 27'h5F90000);
        chk("first_diry", dir_y2, 27'h1F78000);
        chk("first_dirz", dir_z2, 27'h1FC0000);
        @(posedge clk); #1;
        chk("second_pix", {pix_x2, pix_y2}, {11'd1, 11'd0});
        chk("second_dirx", dir_x2, 27'h5F8FC00);
        chk("second_sof", sof2, 0);
        ready2 = 1'b0;
        @(posedge clk); #1;
        chk("full_stall_pix", {valid2, pix_x2, pix_y2}, {1'b1, 11'd1, 11'd0});

        // Frame 1: ready held high, no bubbles, start coinciding with last beat.
        mon_en = 1'b1;
        beats = 0;
        push_frame();
        pulse_start();
        n = 0; done = 1'b0;
        while (!done && n < H*V + 100) begin
            @(negedge clk); n++;
            if (valid && ready && eof) done = 1'b1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("f1_done", done, 1);
        chk("f1_cycles", n, H*V + 2);
        chk("f1_beats", beats, H*V);
        chk("f1_sb_empty", sbq.size(), 0);
        chk("f1_idle_busy", busy, 0);
        chk("f1_idle_valid", valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_start_ignored", {busy, valid}, 0);

        // Frame 2: random backpressure, start pulsed mid-frame.
        rand_ready = 1'b1;
        beats = 0;
        push_frame();
        pulse_start();
        n = 0; done = 1'b0;
        while (!done && n < 8*H*V) begin
            @(negedge clk); n++;
            start = (n == 2000);
            if (valid && ready && eof) done = 1'b1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        rand_ready = 1'b0;
        chk("f2_done", done, 1);
        chk("f2_beats", beats, H*V);
        chk("f2_sb_empty", sbq.size(), 0);
        chk("f2_idle_busy", busy, 0);

        // Frame 3: asynchronous reset while pixel (100,50) is on the output.
        rand_ready = 1'b1;
        beats = 0;
        push_frame();
        pulse_start();
        n = 0; done = 1'b0;
        while (!done && n < 8*H*V) begin
            @(negedge clk); n++;
            if (valid && pix_x == CW'(100) && pix_y == CW'(50)) done = 1'b1;
        end
        chk("f3_reached", done, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_quiet", {busy, valid}, 0);

        // Frame 4: restart from (0,0) after the abort.
        beats = 0;
        push_frame();
        pulse_start();
        @(posedge clk); #1;
        chk("restart_c1_valid", valid, 0);
        @(posedge clk); #1;
        chk("restart_first", {valid, sof, pix_x, pix_y}, {1'b1, 1'b1, 22'd0});
        n = 0; done = 1'b0;
        while (!done && n < H*V + 100) begin
            @(negedge clk); n++;
            if (valid && ready && eof) done = 1'b1;
        end
        @(posedge clk); #1;
        chk("f4_done", done, 1);
        chk("f4_beats", beats, H*V);
        chk("f4_sb_empty", sbq.size(), 0);
        chk("f4_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
